// File: rtl/pr_scoreboard.sv
// pr_scoreboard
//   Register busy scoreboard with producer tags. Each architectural register
//   carries a busy bit and the tag of the execution unit that will write it.
//   Issue ports mark a destination busy. Writeback ports clear it, but only
//   when the writeback comes from the unit that currently owns the register.
//   A stale writeback left behind after a WAW re-issue is therefore dropped.
//   Register 0 is hard-wired idle.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   busy_en     per issue port valid (NISSUE)
//   busy_rn     per issue port destination register, port k at [k*RN_W +: RN_W]
//   busy_tag    per issue port producer tag, port k at [k*TAG_W +: TAG_W]
//   free_en     per writeback port valid (NFREE)
//   free_rn     per writeback port register
//   free_tag    per writeback port tag of the writing unit
//   flush       clears every busy bit; tags are kept
//   reg_busy    registered busy bit per register
//   reg_tag     registered producer tag per register, reg r at [r*TAG_W +: TAG_W]
//   busy_count  registered population count of reg_busy
//
// Port semantics: there is no back-pressure. A port whose *_en bit is high
// is acted on at the next rising edge. A port whose *_en bit is low is
// ignored entirely.
module pr_scoreboard #(
    parameter int NREGS  = 64,
    parameter int RN_W   = 6,
    parameter int NISSUE = 2,
    parameter int NFREE  = 2,
    parameter int TAG_W  = 3,
    parameter int CNT_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NISSUE-1:0]         busy_en,
    input  logic [NISSUE*RN_W-1:0]    busy_rn,
    input  logic [NISSUE*TAG_W-1:0]   busy_tag,
    input  logic [NFREE-1:0]          free_en,
    input  logic [NFREE*RN_W-1:0]     free_rn,
    input  logic [NFREE*TAG_W-1:0]    free_tag,
    input  logic                      flush,
    output logic [NREGS-1:0]          reg_busy,
    output logic [NREGS*TAG_W-1:0]    reg_tag,
    output logic [CNT_W-1:0]          busy_count
);

    logic [NREGS-1:0]       busy_q, busy_d;
    logic [NREGS*TAG_W-1:0] tag_q,  tag_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        cnt_d  = '0;

        // Register 0 is skipped, so its busy bit and tag keep their reset value of 0.
        for (int r = 1; r < NREGS; r++) begin
            // A free is tested against the pre-edge owner tag. Frees are
            // applied first so that a same-cycle issue overrides them.
            for (int j = 0; j < NFREE; j++) begin
                if (free_en[j] && busy_q[r] &&
                    free_rn[j*RN_W +: RN_W] == RN_W'(r) &&
                    free_tag[j*TAG_W +: TAG_W] == tag_q[r*TAG_W +: TAG_W]) begin
                    busy_d[r] = 1'b0;
                end
            end
            // Ascending port order: the highest-numbered port writes last and owns the tag.
            for (int k = 0; k < NISSUE; k++) begin
                if (busy_en[k] && busy_rn[k*RN_W +: RN_W] == RN_W'(r)) begin
                    busy_d[r]                = 1'b1;
                    tag_d[r*TAG_W +: TAG_W]  = busy_tag[k*TAG_W +: TAG_W];
                end
            end
        end

        // Flush discards the issues and frees of this cycle. Tags are left as they were.
        if (flush) begin
            busy_d = '0;
            tag_d  = tag_q;
        end

        // The count comes from next-state, so it stays aligned with reg_busy.
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            tag_q  <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign reg_busy   = busy_q;
    assign reg_tag    = tag_q;
    assign busy_count = cnt_q;

endmodule

// File: doc/pr_scoreboard.md
PR_SCOREBOARD -- requirements
Module: pr_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 64, number of architectural registers (power of two, >=2).
REQ-002 SHALL have parameter RN_W, default 6, register-number width (log2 NREGS).
REQ-003 SHALL have parameter NISSUE, default 2, number of issue (mark-busy) ports.
REQ-004 SHALL have parameter NFREE, default 2, number of writeback (free) ports.
REQ-005 SHALL have parameter TAG_W, default 3, producer-tag width (execution-unit ID).
REQ-006 SHALL have parameter CNT_W, default 7, busy-count width (>= log2(NREGS+1)).
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-009 busy_en  input  NISSUE  per-port issue valid.
REQ-010 busy_rn  input  NISSUE*RN_W  per-port destination register, port k at bits [k*RN_W +: RN_W].
REQ-011 busy_tag  input  NISSUE*TAG_W  per-port producer tag.
REQ-012 free_en  input  NFREE  per-port writeback valid.
REQ-013 free_rn  input  NFREE*RN_W  per-port register being written back.
REQ-014 free_tag  input  NFREE*TAG_W  tag of unit performing the writeback.
REQ-015 flush  input  1  pipeline flush; clears all pending state.
REQ-016 reg_busy  output  NREGS  registered busy bit per register.
REQ-017 reg_tag  output  NREGS*TAG_W  registered current producer tag per register.
REQ-018 busy_count  output  CNT_W  registered population count of reg_busy.

Function
REQ-019 Register 0 SHALL never become busy; issues to r0 ignored, reg_busy[0] and reg_tag[0] constant 0.
REQ-020 Issue on port k with busy_en[k]=1, rn!=0 SHALL set reg_busy[rn]=1 and reg_tag[rn]=busy_tag[k] at next edge (1-cycle latency).
REQ-021 Free on port j with free_en[j]=1 SHALL clear reg_busy[rn] next edge only if reg_busy[rn]=1 and reg_tag[rn]==free_tag[j] (pre-edge values); otherwise ignored (stale writeback after WAW re-issue).
REQ-022 Free with free_en[j]=0 SHALL have no effect regardless of free_rn.
REQ-023 reg_tag[rn] SHALL hold its value when register freed; only an issue changes it.
REQ-024 Same register issued and freed same cycle: issue SHALL win (busy=1, tag=new issue tag).
REQ-025 Same register on multiple issue ports same cycle: highest-numbered port SHALL win the tag; busy=1.
REQ-026 Same register on multiple free ports same cycle: clear if any port satisfies REQ-021.
REQ-027 Re-issue of an already-busy register SHALL overwrite tag; busy remains 1.
REQ-028 flush=1 SHALL clear all reg_busy and busy_count to 0 next edge, overriding same-cycle issues and frees; reg_tag unchanged.
REQ-029 busy_count SHALL equal popcount of reg_busy in the same cycle (computed from next-state, registered alongside reg_busy, no extra latency).
REQ-030 Outputs SHALL be purely registered; no combinational input-to-output path.

Reset
REQ-031 rst_n=0 at a rising edge SHALL set reg_busy=0, reg_tag=0, busy_count=0, overriding flush, issue and free.
REQ-032 Reset asserted mid-operation (registers busy) SHALL clear all state at that edge; issues presented during reset ignored.
REQ-033 First edge with rst_n=1 SHALL process inputs normally.

Verification
REQ-034 Issue r5 tag 2 port0 -> next cycle reg_busy[5]=1, reg_tag[5]=2, busy_count=1; free r5 tag 2 -> reg_busy[5]=0, busy_count=0, reg_tag[5]=2.
REQ-035 Issue r7 tag 1, then r7 tag 4, then free r7 tag 1 -> reg_busy[7] stays 1; free r7 tag 4 -> cleared.
REQ-036 Same cycle: port0 issue r9 tag 1, port1 issue r9 tag 3, free0 r9 (previously busy tag 0) -> reg_busy[9]=1, reg_tag[9]=3, count +0 net.
REQ-037 Issue r0 on all ports plus r63 -> reg_busy[0]=0, reg_busy[63]=1, busy_count=1.
REQ-038 Fill r1..r63 busy (busy_count=63), then flush with concurrent issue r3 -> all reg_busy=0, busy_count=0.
REQ-039 Randomized issue/free/flush for 10k cycles vs reference model -> reg_busy, reg_tag, busy_count match every cycle; rst_n pulse mid-run clears all.
